// File: rtl/vram_wr_sched.sv
// Video-RAM write scheduler: merges CPU writes, screen fills and a loader
// stream onto one registered write port with fixed priority CPU > fill > loader.
module vram_wr_sched #(
  parameter logic [12:0] FILL_END     = 13'h1AFF,
  parameter bit          CLR_ON_RESET = 1'b1,
  parameter logic [7:0]  RST_PIX      = 8'h00,
  parameter logic [7:0]  RST_ATTR     = 8'h38
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_wr,
  input  logic        ld_valid,
  input  logic [12:0] ld_addr,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  input  logic        fill_start,
  input  logic [7:0]  fill_pix,
  input  logic [7:0]  fill_attr,
  output logic        fill_busy,
  output logic        fill_done,
  output logic [12:0] aw,
  output logic [7:0]  di,
  output logic        we
);

  typedef enum logic {IDLE, FILL} state_t;

  localparam state_t RST_STATE = CLR_ON_RESET ? FILL : IDLE;

  state_t      state, state_n;
  logic [12:0] cnt, cnt_n;
  logic [7:0]  pix_r, pix_n, attr_r, attr_n;
  logic [12:0] aw_n;
  logic [7:0]  di_n;
  logic        we_n, done_n;
  logic        cpu_hit;

  assign cpu_hit   = cpu_wr & (cpu_a[15:13] == 3'b010) & (cpu_a[12:0] <= FILL_END);
  // Gated by resetn so the loader is never acknowledged while held in reset.
  assign ld_ready  = resetn & (state == IDLE) & ~cpu_hit;
  assign fill_busy = (state == FILL);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pix_n   = pix_r;
    attr_n  = attr_r;
    we_n    = 1'b0;
    aw_n    = aw;
    di_n    = di;
    done_n  = 1'b0;

    if (cpu_hit) begin
      we_n = 1'b1;
      aw_n = cpu_a[12:0];
      di_n = cpu_do;
    end

    case (state)
      IDLE: begin
        if (fill_start) begin
          pix_n   = fill_pix;
          attr_n  = fill_attr;
          cnt_n   = '0;
          state_n = FILL;
        end
        if (ld_ready && ld_valid && (ld_addr <= FILL_END)) begin
          we_n = 1'b1;
          aw_n = ld_addr;
          di_n = ld_data;
        end
      end
      FILL: begin
        if (!cpu_hit) begin
          we_n = 1'b1;
          aw_n = cnt;
          di_n = (cnt < 13'h1800) ? pix_r : attr_r;
          if (cnt == FILL_END) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            cnt_n = cnt + 13'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= RST_STATE;
      cnt       <= '0;
      pix_r     <= RST_PIX;
      attr_r    <= RST_ATTR;
      we        <= 1'b0;
      aw        <= '0;
      di        <= '0;
      fill_done <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pix_r     <= pix_n;
      attr_r    <= attr_n;
      we        <= we_n;
      aw        <= aw_n;
      di        <= di_n;
      fill_done <= done_n;
    end
  end

endmodule

// File: tb/tb_vram_wr_sched.sv
// Directed bench for vram_wr_sched: reset fill, CPU window decode, fill with
// interleaved CPU writes, loader stream, ignored fill_start and mid-fill reset.
module tb_vram_wr_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_do;
  logic        cpu_wr;
  logic        ld_valid;
  logic [12:0] ld_addr;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        fill_start;
  logic [7:0]  fill_pix;
  logic [7:0]  fill_attr;
  logic        fill_busy;
  logic        fill_done;
  logic [12:0] aw;
  logic [7:0]  di;
  logic        we;

  int checks = 0;
  int errors = 0;

  vram_wr_sched #(
    .FILL_END(13'h1AFF),
    .CLR_ON_RESET(1'b1),
    .RST_PIX(8'h00),
    .RST_ATTR(8'h38)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cpu_a(cpu_a), .cpu_do(cpu_do), .cpu_wr(cpu_wr),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .fill_start(fill_start), .fill_pix(fill_pix), .fill_attr(fill_attr),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .aw(aw), .di(di), .we(we)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; cpu_a = '0; cpu_do = '0; cpu_wr = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    fill_start = 1'b0; fill_pix = '0; fill_attr = '0;
    #12;
    checks++;
    if (we !== 1'b0 || aw !== 13'h0 || di !== 8'h00 || fill_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: we=%b aw=%h di=%h done=%b, expected 0/0000/00/0", we, aw, di, fill_done);
    end
    checks++;
    if (ld_ready !== 1'b0 || fill_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags: ld_ready=%b fill_busy=%b, expected 0/1", ld_ready, fill_busy);
    end
  endtask

  task automatic test_reset_fill();
    int writes = 0;
    int dones = 0;
    int bad = 0;
    logic [7:0] exp_di;
    step();
    resetn = 1'b1;
    for (int c = 0; c < 8000 && writes < 6912; c++) begin
      step();
      if (fill_done === 1'b1) dones++;
      if (we === 1'b1) begin
        exp_di = (writes < 'h1800) ? 8'h00 : 8'h38;
        if (bad == 0 && (aw !== 13'(writes) || di !== exp_di)) begin
          bad = 1;
          $display("FAIL reset_fill_seq: aw=%h di=%h, expected aw=%h di=%h", aw, di, 13'(writes), exp_di);
        end
        writes++;
      end
    end
    for (int c = 0; c < 4; c++) begin
      step();
      if (fill_done === 1'b1) dones++;
      if (we === 1'b1) writes++;
    end
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (writes != 6912) begin
      errors++;
      $display("FAIL reset_fill_count: writes=%0d, expected 6912", writes);
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL reset_fill_done: pulses=%0d, expected 1", dones);
    end
    checks++;
    if (fill_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_fill_busy: fill_busy=%b, expected 0", fill_busy);
    end
  endtask

  task automatic test_cpu_window();
    cpu_a = 16'h5800; cpu_do = 8'h47; cpu_wr = 1'b1;
    step();
    cpu_wr = 1'b0;
    checks++;
    if (we !== 1'b1 || aw !== 13'h1800 || di !== 8'h47) begin
      errors++;
      $display("FAIL cpu_5800: we=%b aw=%h di=%h, expected 1/1800/47", we, aw, di);
    end
    step();
    checks++;
    if (we !== 1'b0 || aw !== 13'h1800 || di !== 8'h47) begin
      errors++;
      $display("FAIL cpu_hold: we=%b aw=%h di=%h, expected 0/1800/47", we, aw, di);
    end
    cpu_a = 16'h5B00; cpu_do = 8'h99; cpu_wr = 1'b1;
    step();
    checks++;
    if (we !== 1'b0) begin
      errors++;
      $display("FAIL cpu_5b00: we=%b, expected 0", we);
    end
    cpu_a = 16'h3FFF;
    step();
    cpu_wr = 1'b0;
    checks++;
    if (we !== 1'b0) begin
      errors++;
      $display("FAIL cpu_3fff: we=%b, expected 0", we);
    end
    step();
  endtask

  task automatic test_fill_with_cpu();
    int fidx = 0;
    int cpu_writes = 1;
    int writes = 0;
    int bad = 0;
    logic cpu_now;
    logic [7:0] exp_di;
    // CPU write and fill_start in the same IDLE cycle.
    fill_pix = 8'hFF; fill_attr = 8'h07; fill_start = 1'b1;
    cpu_a = 16'h4000; cpu_do = 8'h5A; cpu_wr = 1'b1;
    step();
    fill_start = 1'b0; cpu_wr = 1'b0;
    checks++;
    if (we !== 1'b1 || aw !== 13'h0000 || di !== 8'h5A || fill_busy !== 1'b1) begin
      errors++;
      $display("FAIL fill_cpu_start: we=%b aw=%h di=%h busy=%b, expected 1/0000/5a/1", we, aw, di, fill_busy);
    end
    for (int c = 1; c < 12000 && fidx < 6912; c++) begin
      cpu_now = (c % 3 == 0);
      cpu_wr = cpu_now; cpu_do = 8'(c);
      step();
      cpu_wr = 1'b0;
      if (we === 1'b1) writes++;
      if (cpu_now) begin
        cpu_writes++;
        if (bad == 0 && (we !== 1'b1 || aw !== 13'h0 || di !== 8'(c))) begin
          bad = 1;
          $display("FAIL fill_cpu_write: we=%b aw=%h di=%h, expected 1/0000/%h", we, aw, di, 8'(c));
        end
      end else begin
        exp_di = (fidx < 'h1800) ? 8'hFF : 8'h07;
        if (bad == 0 && (we !== 1'b1 || aw !== 13'(fidx) || di !== exp_di)) begin
          bad = 1;
          $display("FAIL fill_cpu_seq: we=%b aw=%h di=%h, expected 1/%h/%h", we, aw, di, 13'(fidx), exp_di);
        end
        fidx++;
      end
      if (bad != 0) break;
    end
    step();
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (writes + 1 != 6912 + cpu_writes || fill_busy !== 1'b0) begin
      errors++;
      $display("FAIL fill_cpu_total: writes=%0d busy=%b, expected %0d/0", writes + 1, fill_busy, 6912 + cpu_writes);
    end
  endtask

  task automatic test_loader();
    int idx = 0;
    int bad = 0;
    logic cpu_now;
    cpu_a = 16'h4005;
    for (int c = 0; c < 40 && idx < 10; c++) begin
      cpu_now = (c % 4 == 1);
      cpu_wr = cpu_now; cpu_do = 8'(8'h10 + c);
      ld_valid = 1'b1; ld_addr = 13'(13'h0100 + idx); ld_data = 8'(8'hA0 + idx);
      #1;
      if (bad == 0 && ld_ready !== !cpu_now) begin
        bad = 1;
        $display("FAIL loader_ready: ld_ready=%b, expected %b", ld_ready, !cpu_now);
      end
      step();
      if (cpu_now) begin
        if (bad == 0 && (we !== 1'b1 || aw !== 13'h0005 || di !== 8'(8'h10 + c))) begin
          bad = 1;
          $display("FAIL loader_cpu: we=%b aw=%h di=%h, expected 1/0005/%h", we, aw, di, 8'(8'h10 + c));
        end
      end else begin
        if (bad == 0 && (we !== 1'b1 || aw !== 13'(13'h0100 + idx) || di !== 8'(8'hA0 + idx))) begin
          bad = 1;
          $display("FAIL loader_write: we=%b aw=%h di=%h, expected 1/%h/%h", we, aw, di, 13'(13'h0100 + idx), 8'(8'hA0 + idx));
        end
        idx++;
      end
    end
    cpu_wr = 1'b0;
    checks++;
    if (bad != 0 || idx != 10) begin
      errors++;
      $display("FAIL loader_stream: bytes=%0d bad=%0d, expected 10/0", idx, bad);
    end
    ld_addr = 13'h1B00; ld_data = 8'hEE;
    #1;
    checks++;
    if (ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL loader_oob_ready: ld_ready=%b, expected 1", ld_ready);
    end
    step();
    ld_valid = 1'b0;
    checks++;
    if (we !== 1'b0) begin
      errors++;
      $display("FAIL loader_oob_write: we=%b, expected 0", we);
    end
  endtask

  task automatic test_ignore_and_reset();
    int fidx = 0;
    int bad = 0;
    fill_pix = 8'h11; fill_attr = 8'h22; fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    while (fidx < 'h800 && bad == 0) begin
      if (fidx == 100) begin
        fill_start = 1'b1; fill_pix = 8'h33;
      end
      step();
      fill_start = 1'b0;
      if (we !== 1'b1 || aw !== 13'(fidx) || di !== 8'h11) begin
        bad = 1;
        $display("FAIL ignore_restart: we=%b aw=%h di=%h, expected 1/%h/11", we, aw, di, 13'(fidx));
      end
      fidx++;
    end
    checks++;
    if (bad != 0) errors++;
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (we !== 1'b0 || aw !== 13'h0 || di !== 8'h00 || fill_done !== 1'b0 || ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: we=%b aw=%h di=%h done=%b rdy=%b, expected 0/0000/00/0/0", we, aw, di, fill_done, ld_ready);
    end
    step();
    step();
    resetn = 1'b1;
    step();
    checks++;
    if (we !== 1'b1 || aw !== 13'h0 || di !== 8'h00 || fill_busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_addr: we=%b aw=%h di=%h busy=%b, expected 1/0000/00/1", we, aw, di, fill_busy);
    end
    for (int c = 0; c < 8000 && fill_busy === 1'b1; c++) step();
    checks++;
    if (fill_busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_finish: fill_busy=%b, expected 0", fill_busy);
    end
  endtask

  initial begin
    test_reset();
    test_reset_fill();
    test_cpu_window();
    test_fill_with_cpu();
    test_loader();
    test_ignore_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
